// File: rtl/udp_cmd_pkg.sv
// Shared definitions for the UDP command parser: FSM state encoding,
// error codes, default frame magic bytes and record geometry.
package udp_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FETCH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } parser_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_LEN   = 2'd1,
    ERR_MAGIC = 2'd2,
    ERR_OVR   = 2'd3
  } err_code_t;

  localparam logic [7:0] MAGIC0_DEF = 8'h55;
  localparam logic [7:0] MAGIC1_DEF = 8'hAA;

  // Bytes per record ({addr, data_hi, data_lo}) and header size
  localparam int REC_BYTES = 3;
  localparam int HDR_BYTES = 3;

  // Receive RAM is 2 KiB; longer lengths cannot be addressed
  localparam int RAM_AW  = 11;
  localparam int LEN_MAX = 2047;

endpackage

// File: rtl/udp_ram_byte_fetch.sv
// Single-byte fetch from the receive RAM. A req latches the address, holds
// it for RAM_LAT cycles, then raises ack for one cycle with the byte.
// The address returns to 0 once a fetch completes without a follow-on req,
// so the RAM address sits at 0 between packets.
module udp_ram_byte_fetch
  import udp_cmd_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [RAM_AW-1:0] addr,
  output logic              ack,
  output logic [7:0]        rd_byte,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_rdata
);

  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  logic       pend;
  logic [1:0] lat_cnt;

  // Address register and latency counter; ack fires RAM_LAT cycles after req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= '0;
      pend     <= 1'b0;
      lat_cnt  <= '0;
      ack      <= 1'b0;
    end else if (req) begin
      ram_addr <= addr;
      pend     <= 1'b1;
      lat_cnt  <= '0;
      ack      <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (pend) begin
        if (lat_cnt == LAT_LAST) begin
          ack  <= 1'b1;
          pend <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + 2'd1;
        end
      end
      if (ack) ram_addr <= '0;
    end
  end

  // RAM output is valid exactly in the ack cycle
  assign rd_byte = ram_rdata;

endmodule

// File: rtl/udp_cmd_parser.sv
// UDP command parser: reads a received payload byte by byte, validates the
// [MAGIC0][MAGIC1][N] header and emits one register write per 3-byte record.
// Optional feature macro: UDP_CMD_STATS_EN enables saturating good/rejected
// packet counters; when undefined both counter outputs are tied to zero.
module udp_cmd_parser
  import udp_cmd_pkg::*;
#(
  parameter int         RAM_LAT = 1,
  parameter int         MAX_REC = 64,
  parameter logic [7:0] MAGIC0  = MAGIC0_DEF,
  parameter logic [7:0] MAGIC1  = MAGIC1_DEF
) (
  input  logic              gmii_rx_clk,
  input  logic              rst_n,
  input  logic              udp_rec_data_valid,
  input  logic [15:0]       udp_rec_data_length,
  output logic [RAM_AW-1:0] udp_rec_ram_read_addr,
  input  logic [7:0]        udp_rec_ram_rdata,
  output logic              reg_wr_en,
  output logic [7:0]        reg_addr,
  output logic [15:0]       reg_wdata,
  output logic              busy,
  output logic              pkt_done,
  output logic              pkt_err,
  output logic [1:0]        err_code,
  output logic [15:0]       pkt_ok_cnt,
  output logic [15:0]       pkt_err_cnt
);

  parser_state_t     state, state_nxt;
  logic [15:0]       len_q;
  logic [RAM_AW-1:0] byte_idx;
  err_code_t         err_q, err_code_q;
  logic              ovr_q;
  logic [1:0]        rec_ph;
  logic [7:0]        rec_addr_q, rec_hi_q;

  logic              fetch_req, fetch_ack;
  logic [RAM_AW-1:0] fetch_addr;
  logic [7:0]        fetch_byte;
  logic              cap_en, err_set;
  err_code_t         err_val;

  logic [15:0]       len_m3, n_calc, n_rem;
  logic              len_ok;
  logic [RAM_AW-1:0] last_idx;
  logic              ovr_now;

  // Length validation: L must be HDR + REC_BYTES*N with N <= MAX_REC
  assign len_m3   = len_q - 16'(HDR_BYTES);
  assign n_calc   = len_m3 / 16'(REC_BYTES);
  assign n_rem    = len_m3 % 16'(REC_BYTES);
  assign len_ok   = (len_q >= 16'(HDR_BYTES)) && (len_q <= 16'(LEN_MAX)) &&
                    (n_rem == 16'd0) && (n_calc <= 16'(MAX_REC));
  assign last_idx = len_q[RAM_AW-1:0] - 11'd1;
  assign ovr_now  = ovr_q | udp_rec_data_valid;
  assign busy     = (state != ST_IDLE);
  assign err_code = err_code_q;

  udp_ram_byte_fetch #(
    .RAM_LAT (RAM_LAT)
  ) u_fetch (
    .clk       (gmii_rx_clk),
    .rst_n     (rst_n),
    .req       (fetch_req),
    .addr      (fetch_addr),
    .ack       (fetch_ack),
    .rd_byte   (fetch_byte),
    .ram_addr  (udp_rec_ram_read_addr),
    .ram_rdata (udp_rec_ram_rdata)
  );

  // FSM state register
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, fetch requests and per-byte header checks
  always_comb begin
    state_nxt  = state;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    cap_en     = 1'b0;
    err_set    = 1'b0;
    err_val    = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (udp_rec_data_valid) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (len_ok) begin
          fetch_req = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          err_set   = 1'b1;
          err_val   = ERR_LEN;
          state_nxt = ST_ERR;
        end
      end
      ST_FETCH: begin
        if (fetch_ack) begin
          if ((byte_idx == 11'd0 && fetch_byte != MAGIC0) ||
              (byte_idx == 11'd1 && fetch_byte != MAGIC1)) begin
            err_set   = 1'b1;
            err_val   = ERR_MAGIC;
            state_nxt = ST_ERR;
          end else if (byte_idx == 11'd2 && fetch_byte != n_calc[7:0]) begin
            err_set   = 1'b1;
            err_val   = ERR_LEN;
            state_nxt = ST_ERR;
          end else begin
            cap_en = 1'b1;
            if (byte_idx == last_idx) begin
              state_nxt = ST_DONE;
            end else begin
              fetch_req  = 1'b1;
              fetch_addr = byte_idx + 11'd1;
            end
          end
        end
      end
      ST_DONE, ST_ERR: state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // Packet context, record assembly, write strobe and end-of-packet pulses
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      byte_idx   <= '0;
      err_q      <= ERR_NONE;
      err_code_q <= ERR_NONE;
      ovr_q      <= 1'b0;
      rec_ph     <= '0;
      rec_addr_q <= '0;
      rec_hi_q   <= '0;
      reg_wr_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;

      if (state == ST_IDLE && udp_rec_data_valid) begin
        len_q      <= udp_rec_data_length;
        err_q      <= ERR_NONE;
        err_code_q <= ERR_NONE;
        rec_ph     <= '0;
      end
      if (state != ST_IDLE && udp_rec_data_valid) ovr_q <= 1'b1;

      if (fetch_req) byte_idx <= fetch_addr;
      if (err_set)   err_q    <= err_val;

      if (cap_en && byte_idx >= 11'd3) begin
        case (rec_ph)
          2'd0: begin
            rec_addr_q <= fetch_byte;
            rec_ph     <= 2'd1;
          end
          2'd1: begin
            rec_hi_q <= fetch_byte;
            rec_ph   <= 2'd2;
          end
          default: begin
            reg_wr_en <= 1'b1;
            reg_addr  <= rec_addr_q;
            reg_wdata <= {rec_hi_q, fetch_byte};
            rec_ph    <= 2'd0;
          end
        endcase
      end

      // A strobe arriving on the exit cycle still counts as an overrun
      if (state == ST_DONE || state == ST_ERR) begin
        ovr_q <= 1'b0;
        if (err_q != ERR_NONE) begin
          pkt_err    <= 1'b1;
          err_code_q <= err_q;
        end else if (ovr_now) begin
          pkt_err    <= 1'b1;
          err_code_q <= ERR_OVR;
        end else begin
          pkt_done <= 1'b1;
        end
      end
    end
  end

`ifdef UDP_CMD_STATS_EN
  logic [15:0] ok_cnt_q, err_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating packet statistics
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_done) ok_cnt_q  <= sat_inc16(ok_cnt_q);
      if (pkt_err)  err_cnt_q <= sat_inc16(err_cnt_q);
    end
  end

  assign pkt_ok_cnt  = ok_cnt_q;
  assign pkt_err_cnt = err_cnt_q;
`else
  assign pkt_ok_cnt  = 16'h0;
  assign pkt_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_udp_cmd_parser.sv
// Bench for udp_cmd_parser: two instances (RAM_LAT=1 and RAM_LAT=3) share
// stimulus and payload memory; a packet-level model predicts writes and
// the end-of-packet outcome for both.
`timescale 1ns/1ps
module tb_udp_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        strobe;
  logic [15:0] length;
  logic [7:0]  mem [0:2047];

  logic [10:0] addr_a, addr_b;
  logic [7:0]  rdata_a, rdata_b, rb0, rb1;
  logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [7:0]  radr_a, radr_b;
  logic [15:0] wd_a, wd_b, okc_a, okc_b, errc_a, errc_b;
  logic [1:0]  code_a, code_b;

  always #5 clk = ~clk;

  udp_cmd_parser #(.RAM_LAT(1)) dut_a (
    .gmii_rx_clk(clk), .rst_n(rst_n), .udp_rec_data_valid(strobe),
    .udp_rec_data_length(length), .udp_rec_ram_read_addr(addr_a),
    .udp_rec_ram_rdata(rdata_a), .reg_wr_en(wr_a), .reg_addr(radr_a),
    .reg_wdata(wd_a), .busy(busy_a), .pkt_done(done_a), .pkt_err(err_a),
    .err_code(code_a), .pkt_ok_cnt(okc_a), .pkt_err_cnt(errc_a));

  udp_cmd_parser #(.RAM_LAT(3)) dut_b (
    .gmii_rx_clk(clk), .rst_n(rst_n), .udp_rec_data_valid(strobe),
    .udp_rec_data_length(length), .udp_rec_ram_read_addr(addr_b),
    .udp_rec_ram_rdata(rdata_b), .reg_wr_en(wr_b), .reg_addr(radr_b),
    .reg_wdata(wd_b), .busy(busy_b), .pkt_done(done_b), .pkt_err(err_b),
    .err_code(code_b), .pkt_ok_cnt(okc_b), .pkt_err_cnt(errc_b));

  // Receive RAM models: 1-cycle and 3-cycle read latency
  always @(posedge clk) rdata_a <= mem[addr_a];
  always @(posedge clk) begin
    rb0     <= mem[addr_b];
    rb1     <= rb0;
    rdata_b <= rb1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vecs = 0, bad = 0;
  logic [23:0] qa[$], qb[$], log_a[$];
  bit          open_a = 0, open_b = 0, rst_test = 0;
  bit          exp_done;
  logic [1:0]  exp_code;
  int          exp_len, s_cyc, end_cyc_a, end_cyc_b, max_a, max_b;
  int          wcnt_a, wcnt_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    vecs++;
    if (act > lim) begin
      bad++;
      $display("FAIL %s: got %0d, want <= %0d", name, act, lim);
    end
  endtask

  task automatic fail(input string name, input int act, input int req);
    vecs++;
    bad++;
    $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask

  // Packet model: outcome and write list straight from the frame rules
  task automatic model_pkt(input int L, input bit ovr);
    int n;
    logic [23:0] w;
    exp_len = L;
    if (L < 3 || L > 2047 || (L - 3) % 3 != 0 || (L - 3) / 3 > 64) begin
      exp_done = 0; exp_code = 2'd1; return;
    end
    n = (L - 3) / 3;
    if (mem[0] != 8'h55 || mem[1] != 8'hAA) begin
      exp_done = 0; exp_code = 2'd2; return;
    end
    if (int'(mem[2]) != n) begin
      exp_done = 0; exp_code = 2'd1; return;
    end
    for (int r = 0; r < n; r++) begin
      w = {mem[3+3*r], mem[4+3*r], mem[5+3*r]};
      qa.push_back(w);
      qb.push_back(w);
    end
    if (ovr) begin exp_done = 0; exp_code = 2'd3; end
    else     begin exp_done = 1; exp_code = 2'd0; end
  endtask

  task automatic observe(input int d, input logic wr, input logic [7:0] ra,
                         input logic [15:0] wd, input logic dn, input logic er,
                         input logic [1:0] cd, input logic [10:0] ad);
    logic [23:0] e;
    int sz, mx;
    bit op;
    if (d == 0) begin if (int'(ad) > max_a) max_a = int'(ad); end
    else        begin if (int'(ad) > max_b) max_b = int'(ad); end
    if (wr) begin
      if (rst_test) begin
        if (d == 0) wcnt_a++; else wcnt_b++;
      end else begin
        sz = (d == 0) ? qa.size() : qb.size();
        if (sz == 0) fail($sformatf("unexpected write dut%0d", d), int'({ra, wd}), 0);
        else begin
          if (d == 0) begin e = qa.pop_front(); log_a.push_back({ra, wd}); end
          else        e = qb.pop_front();
          check($sformatf("write dut%0d", d), {ra, wd}, e);
        end
      end
    end
    if (dn || er) begin
      op = (d == 0) ? open_a : open_b;
      if (!op) fail($sformatf("unexpected end pulse dut%0d", d), int'({dn, er}), 0);
      else begin
        sz = (d == 0) ? qa.size() : qb.size();
        mx = (d == 0) ? max_a : max_b;
        check($sformatf("outcome dut%0d", d), {dn, er, cd}, {exp_done, ~exp_done, exp_code});
        check($sformatf("writes left dut%0d", d), sz, 0);
        check_le($sformatf("addr bound dut%0d", d), mx, (exp_len > 0) ? exp_len - 1 : 0);
        if (d == 0) begin end_cyc_a = cyc; open_a = 0; end
        else        begin end_cyc_b = cyc; open_b = 0; end
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        observe(0, wr_a, radr_a, wd_a, done_a, err_a, code_a, addr_a);
        observe(1, wr_b, radr_b, wd_b, done_b, err_b, code_b, addr_b);
      end
    end
  end

  task automatic drive_strobe(input int L);
    @(posedge clk); #1;
    strobe = 1'b1;
    length = 16'(L);
    s_cyc  = cyc;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic start_pkt(input int L, input bit ovr);
    qa.delete(); qb.delete(); log_a.delete();
    model_pkt(L, ovr);
    max_a = 0; max_b = 0;
    open_a = 1; open_b = 1;
    drive_strobe(L);
  endtask

  task automatic wait_end();
    int t = 0;
    while ((open_a || open_b) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    #1;
    if (open_a || open_b) begin
      fail("end pulse timeout", int'({open_a, open_b}), 0);
      open_a = 0; open_b = 0;
    end
    qa.delete(); qb.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load_t1();
    logic [7:0] b [9] = '{8'h55, 8'hAA, 8'h02, 8'h10, 8'h12, 8'h34, 8'h11, 8'hAB, 8'hCD};
    for (int i = 0; i < 9; i++) mem[i] = b[i];
  endtask

  task automatic check_zero(input string name);
    check({name, " dut0"}, {wr_a, radr_a, wd_a, busy_a, done_a, err_a, code_a, addr_a}, 64'd0);
    check({name, " dut1"}, {wr_b, radr_b, wd_b, busy_b, done_b, err_b, code_b, addr_b}, 64'd0);
    check({name, " cnt"}, {okc_a, errc_a, okc_b, errc_b}, 64'd0);
  endtask

  task automatic rst_run(input int trig);
    int t = 0;
    int snap;
    bit seen = 0;
    wcnt_a = 0; wcnt_b = 0;
    rst_test = 1;
    drive_strobe(18);
    while (!seen && t < 500) begin
      @(negedge clk); #1;
      t++;
      seen = (trig == 0) ? (wcnt_a != 0) : (wcnt_b != 0);
    end
    if (!seen) fail($sformatf("first write timeout dut%0d", trig), t, 500);
    snap = (trig == 0) ? wcnt_b : wcnt_a;
    rst_n = 1'b0;
    #1;
    check_zero($sformatf("reset abort %0d", trig));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    if (trig == 0) begin
      check("writes after reset dut0", wcnt_a, 1);
      check("writes after reset dut1", wcnt_b, snap);
    end else begin
      check("writes after reset dut1", wcnt_b, 1);
      check("writes after reset dut0", wcnt_a, snap);
    end
    rst_test = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    strobe = 1'b0;
    length = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset state");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Two-record packet
    load_t1();
    start_pkt(9, 0);
    check("model t1 writes", {qa[0], qa[1]}, {24'h101234, 24'h11ABCD});
    wait_end();
    check("t1 write count", log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("t1 write0", log_a[0], 24'h101234);
      check("t1 write1", log_a[1], 24'h11ABCD);
    end
    check("t1 err_code", code_a, 2'd0);
    check("t1 latency lat1", end_cyc_a - s_cyc, 21);
    check("t1 latency lat3", end_cyc_b - s_cyc, 39);

    // Bad second magic byte
    mem[1] = 8'hAB;
    start_pkt(9, 0);
    wait_end();
    check("t2 err_code", {code_a, code_b}, 4'b1010);
    mem[1] = 8'hAA;

    // Length not 3+3N
    start_pkt(8, 0);
    wait_end();
    check("t3 err_code", code_a, 2'd1);
    check_le("t3 err latency", end_cyc_a - s_cyc, 3);
    check("t3 addr max", {max_a, max_b}, 64'd0);

    // N byte disagrees with length
    start_pkt(6, 0);
    wait_end();
    check("t4 err_code", code_b, 2'd1);

    // Empty command packet
    mem[2] = 8'h00;
    start_pkt(3, 0);
    wait_end();
    check("t4 empty code", {code_a, code_b}, 4'd0);
    check("t4 empty writes", log_a.size(), 0);

    // Length boundaries
    start_pkt(2, 0);    wait_end();
    start_pkt(200, 0);  wait_end();
    start_pkt(3000, 0); wait_end();
    mem[0] = 8'h55; mem[1] = 8'hAA; mem[2] = 8'd65;
    start_pkt(198, 0);  wait_end();
    check("65 records code", code_a, 2'd1);

    // Maximum record count
    mem[2] = 8'd64;
    for (int i = 3; i < 195; i++) mem[i] = 8'(i * 7 + 1);
    start_pkt(195, 0);
    wait_end();
    check("64 records count", log_a.size(), 64);
    check("64 records code", code_a, 2'd0);

    // Bad first magic byte
    load_t1();
    mem[0] = 8'h54;
    start_pkt(9, 0);
    wait_end();
    check("magic0 code", code_b, 2'd2);

    // Overrun: second strobe while the first packet is in flight
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    load_t1();
    start_pkt(9, 1);
    repeat (3) @(posedge clk);
    #1 strobe = 1'b1;
    length = 16'd9;
    @(posedge clk);
    #1 strobe = 1'b0;
    wait_end();
    check("ovr writes", log_a.size(), 2);
    check("ovr code", {code_a, code_b}, 4'b1111);
`ifdef UDP_CMD_STATS_EN
    check("ovr stats", {okc_a, errc_a, okc_b, errc_b}, {16'd0, 16'd1, 16'd0, 16'd1});
`else
    check("ovr stats", {okc_a, errc_a, okc_b, errc_b}, 64'd0);
`endif

    // Reset after the first write of a 5-record packet, once per latency
    mem[0] = 8'h55; mem[1] = 8'hAA; mem[2] = 8'h05;
    for (int r = 0; r < 5; r++) begin
      mem[3+3*r] = 8'(8'h20 + r);
      mem[4+3*r] = 8'(8'hA0 + r);
      mem[5+3*r] = 8'(8'h30 + r);
    end
    rst_run(0);
    rst_run(1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
